instr_encoder_loader: RTL and testbench

//   Write-side counterpart of the 16-bit instruction decoder. Accepts decoded instruction

---
 rtl/instr_encoder_loader.sv | 142 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words and streams them into instruction memory.
// Optional ENC_CHECKSUM_EN adds a running XOR checksum of the written words.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_fmt,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [8:0]        in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     prog_len_q, prog_len_d;
    logic                overflow_q, overflow_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
`ifdef ENC_CHECKSUM_EN
    logic [15:0]         csum_q, csum_d;
`endif

    logic        full;
    logic        accept;
    logic [15:0] word;

    assign full     = (prog_len_q == DEPTH);
    assign in_ready = (state_q == S_LOAD) && !full;
    assign accept   = in_valid && in_ready;
    // rs2 and the low imm bits share [8:0]; format picks which one lands there
    assign word     = in_fmt ? {in_opcode, in_rs1, in_imm}
                             : {in_opcode, in_rs1, in_rs2, 6'b0};

    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        overflow_d  = overflow_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ENC_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
`ifdef ENC_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = prog_len_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    prog_len_d  = prog_len_q + ONE;
`ifdef ENC_CHECKSUM_EN
                    csum_d      = csum_q ^ word;
`endif
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end else if (in_valid && full) begin
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prog_len_q  <= '0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ENC_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prog_len_q  <= prog_len_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef ENC_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign prog_len  = prog_len_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
`ifdef ENC_CHECKSUM_EN
    assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 64-word instance and a 4-word instance.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_start;
    logic        in_valid;
    logic        in_fmt;
    logic [3:0]  in_opcode;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [8:0]  in_imm;
    logic        in_last;

    logic        in_ready, mem_we, busy, done, overflow;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [6:0]  prog_len;

    logic        s_in_ready, s_mem_we, s_busy, s_done, s_overflow;
    logic [1:0]  s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic [2:0]  s_prog_len;
`ifdef ENC_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] s_checksum;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .prog_len(prog_len), .busy(busy), .done(done),
        .overflow(overflow)
`ifdef ENC_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    instr_encoder_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .prog_len(s_prog_len), .busy(s_busy), .done(s_done),
        .overflow(s_overflow)
`ifdef ENC_CHECKSUM_EN
        , .checksum(s_checksum)
`endif
    );

    typedef struct {
        logic        fmt;
        logic [3:0]  op;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [8:0]  imm;
        logic        last;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[3];
    vec_t sv[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_last   = v.last;
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    initial begin
        // Junk in ignored fields: imm on R-format, rs2 on I-format
        vt[0] = '{1'b0, 4'h1, 3'd2, 3'd3, 9'h1AB, 1'b0, 16'h14C0};
        vt[1] = '{1'b1, 4'h5, 3'd1, 3'd5, 9'h0A5, 1'b0, 16'h52A5};
        vt[2] = '{1'b1, 4'hF, 3'd7, 3'd2, 9'h1FF, 1'b1, 16'hFFFF};
        sv[0] = '{1'b0, 4'h1, 3'd0, 3'd0, 9'h000, 1'b0, 16'h1000};
        sv[1] = '{1'b0, 4'h2, 3'd1, 3'd0, 9'h000, 1'b0, 16'h2200};
        sv[2] = '{1'b0, 4'h3, 3'd2, 3'd0, 9'h000, 1'b0, 16'h3400};
        sv[3] = '{1'b0, 4'h4, 3'd3, 3'd0, 9'h000, 1'b0, 16'h4600};

        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        in_valid = 1'b0; in_fmt = 1'b0; in_opcode = '0; in_rs1 = '0;
        in_rs2 = '0; in_imm = '0; in_last = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_len", 32'(prog_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);

        // Test 1: back-to-back
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_len0", 32'(prog_len), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(vt[i]);
            chk("t1_rdy", 32'(in_ready), 32'd1);
            step();
            chk("t1_we", 32'(mem_we), 32'd1);
            chk("t1_addr", 32'(mem_addr), 32'(i));
            chk("t1_wdata", 32'(mem_wdata), 32'(vt[i].exp));
            chk("t1_len", 32'(prog_len), 32'(i + 1));
            chk("t1_done", 32'(done), 32'(vt[i].last));
        end
        idle_in();
        step();
        chk("t1_we_end", 32'(mem_we), 32'd0);
        chk("t1_done_end", 32'(done), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_len_end", 32'(prog_len), 32'd3);
`ifdef ENC_CHECKSUM_EN
        chk("t6_csum", 32'(checksum), 32'h0000B99A);
`endif

        // Test 2: gaps between bundles
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(vt[i]);
            step();
            chk("t2_we", 32'(mem_we), 32'd1);
            chk("t2_addr", 32'(mem_addr), 32'(i));
            chk("t2_wdata", 32'(mem_wdata), 32'(vt[i].exp));
            chk("t2_done", 32'(done), 32'(vt[i].last));
            idle_in();
            step();
            chk("t2_gap_we", 32'(mem_we), 32'd0);
        end
        chk("t2_len", 32'(prog_len), 32'd3);
        chk("t2_busy", 32'(busy), 32'd0);

        // Test 3: 4-word memory, overflow on fifth bundle
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(sv[i]);
            chk("t3_rdy", 32'(s_in_ready), 32'd1);
            step();
            chk("t3_we", 32'(s_mem_we), 32'd1);
            chk("t3_addr", 32'(s_mem_addr), 32'(i));
            chk("t3_wdata", 32'(s_mem_wdata), 32'(sv[i].exp));
            chk("t3_len", 32'(s_prog_len), 32'(i + 1));
        end
        chk("t3_busy_full", 32'(s_busy), 32'd1);
        drive(vt[0]);
        in_last = 1'b0;
        chk("t3_rdy_full", 32'(s_in_ready), 32'd0);
        step();
        chk("t3_ovf", 32'(s_overflow), 32'd1);
        chk("t3_done", 32'(s_done), 32'd1);
        chk("t3_we_drop", 32'(s_mem_we), 32'd0);
        chk("t3_len_full", 32'(s_prog_len), 32'd4);
        chk("t3_addr_hold", 32'(s_mem_addr), 32'd3);
        idle_in();
        step();
        chk("t3_done_end", 32'(s_done), 32'd0);
        chk("t3_busy_end", 32'(s_busy), 32'd0);
        chk("t3_ovf_sticky", 32'(s_overflow), 32'd1);
        chk("t3_big_idle", 32'(prog_len), 32'd3);

        // last on the DEPTH-th bundle completes normally
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("t3b_ovf_clr", 32'(s_overflow), 32'd0);
        chk("t3b_len_clr", 32'(s_prog_len), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(sv[i]);
            in_last = (i == 3);
            step();
        end
        chk("t3b_addr", 32'(s_mem_addr), 32'd3);
        chk("t3b_done", 32'(s_done), 32'd1);
        chk("t3b_ovf", 32'(s_overflow), 32'd0);
        chk("t3b_len", 32'(s_prog_len), 32'd4);
        idle_in();
        step();

        // Test 4: reset mid-session
        start = 1'b1;
        step();
        start = 1'b0;
        drive(vt[0]);
        step();
        drive(vt[1]);
        step();
        chk("t4_len2", 32'(prog_len), 32'd2);
        drive(vt[2]);
        rst = 1'b1;
        step();
        chk("t4_we", 32'(mem_we), 32'd0);
        chk("t4_addr", 32'(mem_addr), 32'd0);
        chk("t4_wdata", 32'(mem_wdata), 32'd0);
        chk("t4_len", 32'(prog_len), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
        drive(vt[2]);
        step();
        chk("t4_new_we", 32'(mem_we), 32'd1);
        chk("t4_new_addr", 32'(mem_addr), 32'd0);
        chk("t4_new_wdata", 32'(mem_wdata), 32'h0000FFFF);
        chk("t4_new_len", 32'(prog_len), 32'd1);
        chk("t4_new_done", 32'(done), 32'd1);
        idle_in();
        step();

        // Test 5: start with in_valid in IDLE, start during LOAD
        drive(vt[0]);
        start = 1'b1;
        chk("t5_idle_rdy", 32'(in_ready), 32'd0);
        step();
        start = 1'b0;
        chk("t5_idle_we", 32'(mem_we), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_len0", 32'(prog_len), 32'd0);
        step();
        chk("t5_we1", 32'(mem_we), 32'd1);
        chk("t5_addr0", 32'(mem_addr), 32'd0);
        idle_in();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_restart_busy", 32'(busy), 32'd1);
        chk("t5_restart_len", 32'(prog_len), 32'd1);
        drive(vt[2]);
        step();
        chk("t5_addr1", 32'(mem_addr), 32'd1);
        chk("t5_len2", 32'(prog_len), 32'd2);
        chk("t5_done", 32'(done), 32'd1);
        drive(vt[1]);
        chk("t5_done_rdy", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_hold_rdy", 32'(in_ready), 32'd0);
            chk("t5_hold_we", 32'(mem_we), 32'd0);
            chk("t5_hold_len", 32'(prog_len), 32'd2);
        end
        idle_in();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
